// File: rtl/data_mem_resp.sv
// data_mem_resp: single-port word-organised data memory with a request/grant,
// fixed-latency response interface. Byte, half-word and word loads/stores,
// sign/zero extension of load data, and error responses for bad requests.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; grant is issued here only
// ACCESS | request latched, counting down the extra access cycles
// RESP   | one-cycle response (rvalid), then back to IDLE
module data_mem_resp #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  input  logic        zero_extnd_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);

  logic [31:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        wr_q, zext_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        gnt, enter_resp, in_idle;
  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_size;
  logic        cur_wr, cur_zext, cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic [4:0]  byte_sh, half_sh;
  logic [3:0]  be;
  logic [31:0] wdata_al, rd_word, load_val;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign in_idle    = (state_q == IDLE);
  assign gnt        = !reset && in_idle && data_req_i;
  // With no wait cycles the response is entered straight from the grant edge.
  assign enter_resp = (gnt && NO_WAIT) || (!reset && state_q == ACCESS && cnt_q == 4'd0);

  // In IDLE the request fields are still on the inputs; afterwards only latched copies are used.
  assign cur_addr  = in_idle ? data_addr_i    : addr_q;
  assign cur_wdata = in_idle ? data_wr_data_i : wdata_q;
  assign cur_size  = in_idle ? data_byte_i    : size_q;
  assign cur_wr    = in_idle ? data_wr_i      : wr_q;
  assign cur_zext  = in_idle ? zero_extnd_i   : zext_q;

  assign cur_idx = cur_addr[IDX_W+1:2];
  assign byte_sh = {cur_addr[1:0], 3'b000};
  assign half_sh = {cur_addr[1], 4'b0000};

  // Error classification: reserved size, misalignment, or word index past the array.
  always_comb begin
    cur_err = 1'b0;
    case (cur_size)
      SZ_BYTE: cur_err = 1'b0;
      SZ_HALF: cur_err = cur_addr[0];
      SZ_WORD: cur_err = |cur_addr[1:0];
      default: cur_err = 1'b1;
    endcase
    if ({2'b00, cur_addr[31:2]} >= DEPTH) cur_err = 1'b1;
  end

  // Byte-lane enables and lane-aligned store data.
  always_comb begin
    be       = 4'b1111;
    wdata_al = cur_wdata;
    case (cur_size)
      SZ_BYTE: begin
        be       = 4'b0001 << cur_addr[1:0];
        wdata_al = {24'd0, cur_wdata[7:0]} << byte_sh;
      end
      SZ_HALF: begin
        be       = 4'b0011 << {cur_addr[1], 1'b0};
        wdata_al = {16'd0, cur_wdata[15:0]} << half_sh;
      end
      default: begin
        be       = 4'b1111;
        wdata_al = cur_wdata;
      end
    endcase
  end

  // Load path: pick the addressed lane(s) and extend to 32 bits.
  always_comb begin
    rd_word  = mem[cur_idx];
    rd_byte  = rd_word[byte_sh +: 8];
    rd_half  = rd_word[half_sh +: 16];
    case (cur_size)
      SZ_BYTE: load_val = {{24{!cur_zext && rd_byte[7]}}, rd_byte};
      SZ_HALF: load_val = {{16{!cur_zext && rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt) state_d = NO_WAIT ? RESP : ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, wait counter, latched request and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
      zext_q  <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        addr_q  <= data_addr_i;
        wdata_q <= data_wr_data_i;
        size_q  <= data_byte_i;
        wr_q    <= data_wr_i;
        zext_q  <= zero_extnd_i;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == ACCESS && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        err_q   <= cur_err;
        rdata_q <= (cur_err || cur_wr) ? 32'd0 : load_val;
      end
    end
  end

  // Store commit on the edge entering RESP; the array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_wr && !cur_err) begin
      if (be[0]) mem[cur_idx][7:0]   <= wdata_al[7:0];
      if (be[1]) mem[cur_idx][15:8]  <= wdata_al[15:8];
      if (be[2]) mem[cur_idx][23:16] <= wdata_al[23:16];
      if (be[3]) mem[cur_idx][31:24] <= wdata_al[31:24];
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = !reset && (state_q == RESP);
  assign data_rdata_o  = data_rvalid_o ? rdata_q : 32'd0;
  assign data_err_o    = data_rvalid_o && err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: three instances (WAIT_CYCLES 1, 3, 0) checked
// against a word-array reference model with byte-lane arithmetic.
module tb_data_mem_resp;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst  [3];
  logic        req  [3];
  logic [31:0] addr [3];
  logic [1:0]  bsz  [3];
  logic        wr   [3];
  logic [31:0] wdat [3];
  logic        zx   [3];
  logic        gnt  [3];
  logic        rv   [3];
  logic [31:0] rd   [3];
  logic        er   [3];

  logic [31:0] mref [3][DEPTH];
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  sz;
    logic        w;
    logic [31:0] wd;
    logic        zx;
    logic [31:0] erd;
    logic        eer;
  } dir_t;
  dir_t dq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_resp #(
      .DEPTH(DEPTH),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk           (clk),
      .reset         (rst[g]),
      .data_req_i    (req[g]),
      .data_addr_i   (addr[g]),
      .data_byte_i   (bsz[g]),
      .data_wr_i     (wr[g]),
      .data_wr_data_i(wdat[g]),
      .zero_extnd_i  (zx[g]),
      .data_gnt_o    (gnt[g]),
      .data_rvalid_o (rv[g]),
      .data_rdata_o  (rd[g]),
      .data_err_o    (er[g])
    );
  end

  function automatic int wait_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  // Reference model: memory as 32-bit words, lanes handled with masks and shifts.
  function automatic void model(input int k, input logic [31:0] a, input logic [1:0] sz,
                                input logic w, input logic [31:0] wd, input logic zxt,
                                output logic [31:0] exp_rd, output logic exp_er);
    int unsigned wi, off;
    logic [31:0] word, mask, v;
    wi = a / 4;
    off = a % 4;
    exp_rd = 32'd0;
    exp_er = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) ||
             (sz == 2'd2 && off != 0) || (wi >= DEPTH);
    if (exp_er) return;
    word = mref[k][wi];
    case (sz)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    if (w) begin
      mref[k][wi] = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    end else begin
      v = (word >> (8 * off)) & mask;
      if (!zxt && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (!zxt && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      exp_rd = v;
    end
  endfunction

  // Drives one request, scrambles inputs after grant, returns latency (-1 on timeout).
  task automatic run_txn(input int k, input logic [31:0] t_a, input logic [1:0] t_sz,
                         input logic t_w, input logic [31:0] t_wd, input logic t_zx,
                         output int lat, output logic [31:0] o_rd, output logic o_er);
    int n;
    lat = -1;
    o_rd = 32'd0;
    o_er = 1'b0;
    @(negedge clk);
    req[k] = 1'b1; addr[k] = t_a; bsz[k] = t_sz; wr[k] = t_w; wdat[k] = t_wd; zx[k] = t_zx;
    #1;
    n = 0;
    while (gnt[k] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (gnt[k] !== 1'b1) begin
      req[k] = 1'b0;
      return;
    end
    @(negedge clk);
    req[k] = 1'b0; addr[k] = $urandom; bsz[k] = 2'($urandom); wr[k] = 1'($urandom);
    wdat[k] = $urandom; zx[k] = 1'($urandom);
    #1;
    n = 1;
    while (rv[k] !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (rv[k] === 1'b1) begin
      lat = n;
      o_rd = rd[k];
      o_er = er[k];
    end
  endtask

  task automatic add_dir(input logic [31:0] a, input logic [1:0] sz, input logic w,
                         input logic [31:0] wd, input logic zxt, input logic [31:0] erd,
                         input logic eer);
    dir_t e;
    e.a = a; e.sz = sz; e.w = w; e.wd = wd; e.zx = zxt; e.erd = erd; e.eer = eer;
    dq.push_back(e);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b1; addr[k] = 32'h10; bsz[k] = 2'd2; wr[k] = 1'b0;
      wdat[k] = $urandom; zx[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp += 4;
      if (gnt[k] !== 1'b0) begin n_fail++; $display("FAIL reset_gnt k=%0d got=%b exp=0", k, gnt[k]); end
      if (rv[k] !== 1'b0)  begin n_fail++; $display("FAIL reset_rvalid k=%0d got=%b exp=0", k, rv[k]); end
      if (rd[k] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata k=%0d got=%h exp=0", k, rd[k]); end
      if (er[k] !== 1'b0)  begin n_fail++; $display("FAIL reset_err k=%0d got=%b exp=0", k, er[k]); end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin rst[k] = 1'b0; req[k] = 1'b0; end
  endtask

  task automatic test_init;
    int lat;
    logic [31:0] o_rd, e_rd, wd;
    logic o_er, e_er;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        wd = $urandom;
        model(k, 32'(i * 4), 2'd2, 1'b1, wd, 1'b0, e_rd, e_er);
        run_txn(k, 32'(i * 4), 2'd2, 1'b1, wd, 1'b0, lat, o_rd, o_er);
        n_cmp += 2;
        if (lat != wait_of(k) + 1) begin n_fail++; $display("FAIL init_lat k=%0d i=%0d got=%0d exp=%0d", k, i, lat, wait_of(k) + 1); end
        if (o_er !== e_er || o_rd !== e_rd) begin n_fail++; $display("FAIL init_resp k=%0d i=%0d got=%b/%h exp=%b/%h", k, i, o_er, o_rd, e_er, e_rd); end
      end
    end
  endtask

  task automatic test_directed;
    int lat;
    logic [31:0] o_rd, e_rd;
    logic o_er, e_er;
    add_dir(32'h10, 2'd2, 1, 32'hDEADBEEF, 0, 32'h0, 0);
    add_dir(32'h10, 2'd2, 0, 32'h0,        0, 32'hDEADBEEF, 0);
    add_dir(32'h10, 2'd2, 1, 32'h0,        0, 32'h0, 0);
    add_dir(32'h13, 2'd0, 1, 32'hABCDEF80, 0, 32'h0, 0);
    add_dir(32'h13, 2'd0, 0, 32'h0,        0, 32'hFFFFFF80, 0);
    add_dir(32'h13, 2'd0, 0, 32'h0,        1, 32'h00000080, 0);
    add_dir(32'h10, 2'd2, 0, 32'h0,        0, 32'h80000000, 0);
    add_dir(32'h20, 2'd2, 1, 32'h12345678, 0, 32'h0, 0);
    add_dir(32'h22, 2'd1, 1, 32'h55558001, 0, 32'h0, 0);
    add_dir(32'h22, 2'd1, 0, 32'h0,        0, 32'hFFFF8001, 0);
    add_dir(32'h22, 2'd1, 0, 32'h0,        1, 32'h00008001, 0);
    add_dir(32'h20, 2'd1, 0, 32'h0,        1, 32'h00005678, 0);
    add_dir(32'h20, 2'd2, 0, 32'h0,        0, 32'h80015678, 0);
    add_dir(32'h00, 2'd2, 1, 32'h11111111, 0, 32'h0, 0);
    add_dir(32'h04, 2'd2, 1, 32'hCAFEF00D, 0, 32'h0, 0);
    add_dir(32'h02, 2'd2, 0, 32'h0,        0, 32'h0, 1);
    add_dir(32'h05, 2'd1, 1, 32'hFFFFFFFF, 0, 32'h0, 1);
    add_dir(32'h20, 2'd3, 1, 32'hFFFFFFFF, 0, 32'h0, 1);
    add_dir(32'h100, 2'd2, 1, 32'hBAD0BAD0, 0, 32'h0, 1);
    add_dir(32'h100, 2'd2, 0, 32'h0,       0, 32'h0, 1);
    add_dir(32'h00, 2'd2, 0, 32'h0,        0, 32'h11111111, 0);
    add_dir(32'h04, 2'd2, 0, 32'h0,        0, 32'hCAFEF00D, 0);
    add_dir(32'h20, 2'd2, 0, 32'h0,        0, 32'h80015678, 0);
    foreach (dq[i]) begin
      model(0, dq[i].a, dq[i].sz, dq[i].w, dq[i].wd, dq[i].zx, e_rd, e_er);
      run_txn(0, dq[i].a, dq[i].sz, dq[i].w, dq[i].wd, dq[i].zx, lat, o_rd, o_er);
      n_cmp += 3;
      if (lat != 2) begin n_fail++; $display("FAIL dir_lat #%0d got=%0d exp=2", i, lat); end
      if (o_er !== dq[i].eer) begin n_fail++; $display("FAIL dir_err #%0d got=%b exp=%b", i, o_er, dq[i].eer); end
      if (o_rd !== dq[i].erd) begin n_fail++; $display("FAIL dir_rdata #%0d got=%h exp=%h", i, o_rd, dq[i].erd); end
    end
  endtask

  task automatic test_random;
    int lat, wi, r;
    logic [31:0] a, wd, o_rd, e_rd;
    logic [1:0] sz;
    logic w, z, o_er, e_er;
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 80; t++) begin
        r  = $urandom_range(0, 9);
        wi = (r == 0) ? $urandom_range(DEPTH, DEPTH + 20) : $urandom_range(0, DEPTH - 1);
        a  = 32'(wi * 4) | 32'($urandom_range(0, 3));
        if (r == 1) a = $urandom;
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        w  = 1'($urandom_range(0, 1));
        wd = $urandom;
        z  = 1'($urandom_range(0, 1));
        model(k, a, sz, w, wd, z, e_rd, e_er);
        run_txn(k, a, sz, w, wd, z, lat, o_rd, o_er);
        n_cmp += 3;
        if (lat != wait_of(k) + 1) begin n_fail++; $display("FAIL rand_lat k=%0d t=%0d got=%0d exp=%0d", k, t, lat, wait_of(k) + 1); end
        if (o_er !== e_er) begin n_fail++; $display("FAIL rand_err k=%0d a=%h sz=%0d got=%b exp=%b", k, a, sz, o_er, e_er); end
        if (o_rd !== e_rd) begin n_fail++; $display("FAIL rand_rdata k=%0d a=%h sz=%0d got=%h exp=%h", k, a, sz, o_rd, e_rd); end
      end
    end
  endtask

  task automatic test_reset_mid_access;
    int lat, n, seen;
    logic [31:0] o_rd, e_rd;
    logic o_er, e_er;
    @(negedge clk);
    req[1] = 1'b1; addr[1] = 32'h30; bsz[1] = 2'd2; wr[1] = 1'b1; wdat[1] = ~mref[1][12]; zx[1] = 1'b0;
    #1;
    n = 0;
    while (gnt[1] !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    n_cmp++;
    if (gnt[1] !== 1'b1) begin n_fail++; $display("FAIL mid_rst_gnt got=%b exp=1", gnt[1]); end
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    seen = 0;
    repeat (10) begin
      #1;
      if (rv[1] === 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL mid_rst_rvalid got=%0d pulses exp=0", seen); end
    model(1, 32'h30, 2'd2, 1'b0, 32'd0, 1'b0, e_rd, e_er);
    run_txn(1, 32'h30, 2'd2, 1'b0, 32'd0, 1'b0, lat, o_rd, o_er);
    n_cmp += 3;
    if (lat != 4) begin n_fail++; $display("FAIL mid_rst_lat got=%0d exp=4", lat); end
    if (o_er !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got=%b exp=0", o_er); end
    if (o_rd !== e_rd) begin n_fail++; $display("FAIL mid_rst_rdata got=%h exp=%h", o_rd, e_rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ta [4];
    logic        tw [4];
    logic [31:0] twd [4];
    logic [31:0] expq[$];
    logic [31:0] e_rd;
    logic e_er;
    int gcyc [4];
    int rcyc [4];
    int g, r;
    ta[0] = 32'h40; ta[1] = 32'h40; ta[2] = 32'h44; ta[3] = 32'h44;
    tw[0] = 1'b1;   tw[1] = 1'b0;   tw[2] = 1'b1;   tw[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin twd[i] = $urandom; gcyc[i] = -1; rcyc[i] = -1; end
    g = 0;
    r = 0;
    for (int c = 0; c < 20 && r < 4; c++) begin
      @(negedge clk);
      if (g < 4) begin
        req[2] = 1'b1; addr[2] = ta[g]; bsz[2] = 2'd2; wr[2] = tw[g]; wdat[2] = twd[g]; zx[2] = 1'b0;
      end else begin
        req[2] = 1'b0;
      end
      #1;
      n_cmp++;
      if (gnt[2] === 1'b1 && rv[2] === 1'b1) begin n_fail++; $display("FAIL b2b_overlap cycle=%0d got gnt&rvalid exp exclusive", c); end
      if (rv[2] === 1'b1 && r < 4) begin
        n_cmp++;
        if (rd[2] !== expq[0] || er[2] !== 1'b0) begin
          n_fail++; $display("FAIL b2b_resp #%0d got=%b/%h exp=0/%h", r, er[2], rd[2], expq[0]);
        end
        void'(expq.pop_front());
        rcyc[r] = c;
        r++;
      end
      if (gnt[2] === 1'b1 && g < 4) begin
        model(2, ta[g], 2'd2, tw[g], twd[g], 1'b0, e_rd, e_er);
        expq.push_back(e_rd);
        gcyc[g] = c;
        g++;
      end
    end
    req[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp += 2;
      if (gcyc[i] != 2 * i)     begin n_fail++; $display("FAIL b2b_gnt_cycle #%0d got=%0d exp=%0d", i, gcyc[i], 2 * i); end
      if (rcyc[i] != 2 * i + 1) begin n_fail++; $display("FAIL b2b_rvalid_cycle #%0d got=%0d exp=%0d", i, rcyc[i], 2 * i + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_random();
    test_reset_mid_access();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in the internal data array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning the extra access cycles between request acceptance and response.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port data_req_i  input  1  meaning a load/store request is valid.
REQ-006 SHALL have port data_addr_i  input  32  meaning the byte address.
REQ-007 SHALL have port data_byte_i  input  2  meaning access size: 0 BYTE, 1 HALF_WORD, 2 WORD, 3 reserved.
REQ-008 SHALL have port data_wr_i  input  1  meaning store when 1 and load when 0.
REQ-009 SHALL have port data_wr_data_i  input  32  meaning the store data, right-aligned.
REQ-010 SHALL have port zero_extnd_i  input  1  meaning zero-extend load data when 1 and sign-extend when 0.
REQ-011 SHALL have port data_gnt_o  output  1  meaning the request is accepted this cycle.
REQ-012 SHALL have port data_rvalid_o  output  1  meaning the response is valid, a one-cycle pulse.
REQ-013 SHALL have port data_rdata_o  output  32  meaning the load result, right-aligned and extended.
REQ-014 SHALL have port data_err_o  output  1  meaning the response is an error; qualified by data_rvalid_o.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-016 SHALL assert data_gnt_o combinationally only in IDLE, so that data_gnt_o = (state==IDLE) && data_req_i.
REQ-017 SHALL, on grant, latch addr, size, wr, wdata and zero_extnd, and move to ACCESS (WAIT_CYCLES>0) or directly to RESP (WAIT_CYCLES=0).
REQ-018 SHALL, in ACCESS, count down a 4-bit counter loaded with WAIT_CYCLES-1, and move to RESP on the cycle after the count reaches 0.
REQ-019 SHALL, in RESP, assert data_rvalid_o for exactly one cycle and then return to IDLE; no grant is issued during RESP.
REQ-020 SHALL give a load latency from grant edge to the rvalid cycle of WAIT_CYCLES+1 cycles; stores have the same latency.
REQ-021 SHALL flag a request as an error when any of the following holds: size 3; HALF_WORD with addr[0]!=0; WORD with addr[1:0]!=0; addr[31:2] >= DEPTH.
REQ-022 SHALL, on an error, write nothing, drive data_rdata_o=0, and drive data_err_o=1 in the RESP cycle.
REQ-023 SHALL commit a store to the array on the clock edge that enters RESP, using only the addressed byte lanes: BYTE writes wdata[7:0] to lane addr[1:0]; HALF writes wdata[15:0] to lanes addr[1]*2+1..addr[1]*2; WORD writes all four lanes.
REQ-024 SHALL read the array for a load in the cycle that enters RESP, extract the addressed lane(s), and extend them to 32 bits according to the latched zero_extnd.
REQ-025 SHALL drive data_rdata_o=0 for stores.
REQ-026 SHALL hold data_rdata_o and data_err_o at 0 whenever data_rvalid_o=0.
REQ-027 SHALL use only latched request fields after grant; changes on the inputs after grant have no effect.
REQ-028 SHALL allow back-to-back operation: a request presented in the cycle after RESP (state IDLE) is granted in that cycle.
REQ-029 SHALL make a store followed by a load to the same address return the stored data, with no forwarding needed because the transactions are serialised.

Reset
REQ-030 SHALL, while reset=1 at a clock edge, force state to IDLE, the counter to 0, and the latched fields to 0.
REQ-031 SHALL drive data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0 and data_err_o=0 while reset is asserted.
REQ-032 SHALL NOT clear the array contents on reset.
REQ-033 SHALL drop an in-flight transaction on reset mid-operation (in ACCESS) with no write committed and no response issued.
REQ-034 SHALL NOT grant a request in the same cycle that reset is asserted.

Verification
REQ-035 SHALL cover: WAIT_CYCLES=1, SW 0xDEADBEEF to addr 0x10, then LW addr 0x10 -> gnt in cycle 0, rvalid in cycle 2 with err=0; the load returns 0xDEADBEEF.
REQ-036 SHALL cover: SB 0x80 to addr 0x13 over word 0 at addr 0x10, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
REQ-037 SHALL cover: SH 0x8001 to addr 0x22, then LH 0x22 -> 0xFFFF8001; a zero_extnd load -> 0x00008001; the lower half of the word is unchanged.
REQ-038 SHALL cover: LW addr 0x02, SH addr 0x05, size 3, and addr 4*DEPTH -> each gives rvalid with err=1 and rdata=0; the array is unmodified.
REQ-039 SHALL cover: WAIT_CYCLES=3, SW to addr 0x30 with reset pulsed in the second ACCESS cycle -> no rvalid; a later LW 0x30 returns the prior contents.
REQ-040 SHALL cover: WAIT_CYCLES=0 with data_req_i held high for 4 requests -> a grant every 2 cycles, rvalid in each alternate cycle, and gnt and rvalid never high in the same cycle.
